// File: rtl/keypad_entry_sequencer.sv
// Keypad entry sequencer: collects BCD key presses into a packed multi-digit value.
// Optional backspace input is enabled with `define ENTRY_BACKSPACE_EN.
module keypad_entry_sequencer #(
  parameter int N_DIGITS  = 4,
  parameter int TIMEOUT_S = 5
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            load,
  input  logic [3:0]                      digit,
  input  logic                            pgt_1hz,
  input  logic                            confirm,
  input  logic                            cancel,
`ifdef ENTRY_BACKSPACE_EN
  input  logic                            backspace,
`endif
  output logic                            enablen,
  output logic [4*N_DIGITS-1:0]           value,
  output logic [$clog2(N_DIGITS+1)-1:0]   count,
  output logic                            entry_valid,
  output logic                            timeout,
  output logic                            busy
);

  localparam int VW = 4 * N_DIGITS;
  localparam int CW = $clog2(N_DIGITS + 1);
  localparam int TW = (TIMEOUT_S > 0) ? $clog2(TIMEOUT_S + 1) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, FULL, DONE} state_e;

  state_e          state_q, state_d;
  logic [VW-1:0]   value_q, value_d;
  logic [CW-1:0]   count_q, count_d;
  logic [TW-1:0]   sec_q, sec_d;
  logic [TW:0]     secInc;
  logic            timeout_q, timeout_d;
  logic            enablen_q;
  logic            loadPrev_q, confirmPrev_q, cancelPrev_q, tickPrev_q;
  logic            keyEdge, confirmEdge, cancelEdge, tickEdge;
`ifdef ENTRY_BACKSPACE_EN
  logic            backPrev_q;
  logic            backEdge;
  assign backEdge = backspace & ~backPrev_q;
`endif

  assign keyEdge     = load & ~loadPrev_q & (digit <= 4'd9);
  assign confirmEdge = confirm & ~confirmPrev_q;
  assign cancelEdge  = cancel & ~cancelPrev_q;
  assign tickEdge    = pgt_1hz & ~tickPrev_q;
  assign secInc      = {1'b0, sec_q} + (TW+1)'(1);

  // Priority inside an active entry: cancel, confirm, backspace, key, timeout tick.
  always_comb begin
    state_d   = state_q;
    value_d   = value_q;
    count_d   = count_q;
    sec_d     = sec_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (keyEdge) begin
          value_d = VW'(digit);
          count_d = CW'(1);
          sec_d   = '0;
          state_d = (N_DIGITS == 1) ? FULL : COLLECT;
        end
      end
      COLLECT, FULL: begin
        if (cancelEdge) begin
          value_d = '0;
          count_d = '0;
          state_d = IDLE;
        end else if (confirmEdge) begin
          state_d = DONE;
`ifdef ENTRY_BACKSPACE_EN
        end else if (backEdge) begin
          value_d = value_q >> 4;
          count_d = count_q - CW'(1);
          sec_d   = '0;
          state_d = (count_q == CW'(1)) ? IDLE : COLLECT;
`endif
        end else if (keyEdge && state_q == COLLECT) begin
          value_d = (value_q << 4) | VW'(digit);
          count_d = count_q + CW'(1);
          sec_d   = '0;
          state_d = (count_q + CW'(1) == CW'(N_DIGITS)) ? FULL : COLLECT;
        end else if (TIMEOUT_S != 0 && tickEdge) begin
          if (secInc == (TW+1)'(TIMEOUT_S)) begin
            timeout_d = 1'b1;
            value_d   = '0;
            count_d   = '0;
            state_d   = IDLE;
          end else begin
            sec_d = secInc[TW-1:0];
          end
        end
      end
      DONE: begin
        count_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) sec_d = '0;
  end

  // Edge registers reset high so inputs already asserted at reset release are not seen as edges.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      value_q       <= '0;
      count_q       <= '0;
      sec_q         <= '0;
      timeout_q     <= 1'b0;
      enablen_q     <= 1'b1;
      loadPrev_q    <= 1'b1;
      confirmPrev_q <= 1'b1;
      cancelPrev_q  <= 1'b1;
      tickPrev_q    <= 1'b1;
`ifdef ENTRY_BACKSPACE_EN
      backPrev_q    <= 1'b1;
`endif
    end else begin
      state_q       <= state_d;
      value_q       <= value_d;
      count_q       <= count_d;
      sec_q         <= sec_d;
      timeout_q     <= timeout_d;
      enablen_q     <= (state_d == FULL) || (state_d == DONE);
      loadPrev_q    <= load;
      confirmPrev_q <= confirm;
      cancelPrev_q  <= cancel;
      tickPrev_q    <= pgt_1hz;
`ifdef ENTRY_BACKSPACE_EN
      backPrev_q    <= backspace;
`endif
    end
  end

  assign enablen     = enablen_q;
  assign value       = value_q;
  assign count       = count_q;
  assign entry_valid = (state_q == DONE);
  assign timeout     = timeout_q;
  assign busy        = (state_q == COLLECT) || (state_q == FULL);

endmodule

// File: tb/tb_keypad_entry_sequencer.sv
// Randomized + directed bench for keypad_entry_sequencer against a queue-based entry model.
module tb_keypad_entry_sequencer;

  localparam int N  = 4;
  localparam int TO = 5;
  localparam int VW = 4 * N;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          resetn;
  logic          load, confirm, cancel, pgt_1hz, backspace;
  logic [3:0]    digit;
  logic          enablen, entry_valid, timeout, busy;
  logic [VW-1:0] value;
  logic [CW-1:0] count;

  int checks = 0;
  int failures = 0;

  // Model: digits currently displayed (oldest first), entry phase and second count.
  int digs[$];
  int mPhase;
  int mCount;
  int mSec;
  bit mTimeout, mEnablen;
  bit pLoad, pConf, pCanc, pTick, pBack;

  keypad_entry_sequencer #(.N_DIGITS(N), .TIMEOUT_S(TO)) dut (
    .clk(clk), .resetn(resetn), .load(load), .digit(digit), .pgt_1hz(pgt_1hz),
    .confirm(confirm), .cancel(cancel),
`ifdef ENTRY_BACKSPACE_EN
    .backspace(backspace),
`endif
    .enablen(enablen), .value(value), .count(count), .entry_valid(entry_valid),
    .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [VW-1:0] packDigs();
    logic [VW-1:0] v = '0;
    foreach (digs[i]) v = (v << 4) | VW'(digs[i]);
    return v;
  endfunction

  task automatic modelReset();
    digs.delete();
    mPhase = 0; mCount = 0; mSec = 0; mTimeout = 0; mEnablen = 1;
    pLoad = 1; pConf = 1; pCanc = 1; pTick = 1; pBack = 1;
  endtask

  task automatic modelStep();
    bit keyE, confE, cancE, tickE, backE;
    keyE  = load && !pLoad && (digit <= 4'd9);
    confE = confirm && !pConf;
    cancE = cancel && !pCanc;
    tickE = pgt_1hz && !pTick;
`ifdef ENTRY_BACKSPACE_EN
    backE = backspace && !pBack;
`else
    backE = 0;
`endif
    mTimeout = 0;
    if (mPhase == 2) begin
      mPhase = 0; mCount = 0; mSec = 0;
    end else if (mPhase == 0) begin
      if (keyE) begin
        digs.delete(); digs.push_back(int'(digit));
        mCount = 1; mSec = 0; mPhase = 1;
      end
    end else begin
      if (cancE) begin
        digs.delete(); mCount = 0; mSec = 0; mPhase = 0;
      end else if (confE) begin
        mPhase = 2; mSec = 0;
      end else if (backE) begin
        void'(digs.pop_back()); mCount--; mSec = 0;
        if (mCount == 0) mPhase = 0;
      end else if (keyE && mCount < N) begin
        digs.push_back(int'(digit));
        if (digs.size() > N) void'(digs.pop_front());
        mCount++; mSec = 0;
      end else if (tickE && TO > 0) begin
        mSec++;
        if (mSec == TO) begin
          mTimeout = 1; digs.delete(); mCount = 0; mSec = 0; mPhase = 0;
        end
      end
    end
    mEnablen = (mPhase == 2) || (mPhase == 1 && mCount == N);
    pLoad = load; pConf = confirm; pCanc = cancel; pTick = pgt_1hz; pBack = backspace;
  endtask

  task automatic compareAll();
    checkOutput("enablen",     32'(enablen),     32'(mEnablen));
    checkOutput("value",       32'(value),       32'(packDigs()));
    checkOutput("count",       32'(count),       32'(mCount));
    checkOutput("entry_valid", 32'(entry_valid), 32'(mPhase == 2));
    checkOutput("timeout",     32'(timeout),     32'(mTimeout));
    checkOutput("busy",        32'(busy),        32'(mPhase == 1));
  endtask

  task automatic stepCycle();
    @(posedge clk);
    modelStep();
    #1;
    compareAll();
  endtask

  task automatic applyStimulus(input bit ld, input logic [3:0] dg, input bit cf, input bit cn,
                               input bit tk, input bit bk);
    load = ld; digit = dg; confirm = cf; cancel = cn; pgt_1hz = tk; backspace = bk;
    stepCycle();
  endtask

  task automatic keyPress(input logic [3:0] dg);
    applyStimulus(1, dg, 0, 0, 0, 0);
    applyStimulus(0, dg, 0, 0, 0, 0);
  endtask

  task automatic idleCycle();
    applyStimulus(0, 4'd0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset with every input held high: nothing may be taken as an edge on release.
    resetn = 0; load = 1; digit = 4'd3; confirm = 1; cancel = 1; pgt_1hz = 1; backspace = 1;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    compareAll();
    checkOutput("rst_enablen", 32'(enablen), 32'd1);
    resetn = 1;
    applyStimulus(1, 4'd3, 1, 1, 1, 1);
    checkOutput("rel_enablen", 32'(enablen), 32'd0);
    checkOutput("rel_count",   32'(count),   32'd0);
    checkOutput("rel_value",   32'(value),   32'd0);
    idleCycle();

    keyPress(4'd1); keyPress(4'd2); keyPress(4'd3);
    checkOutput("k123_value", 32'(value), 32'h0123);
    checkOutput("k123_count", 32'(count), 32'd3);
    applyStimulus(0, 4'd0, 1, 0, 0, 0);
    checkOutput("conf_pulse", 32'(entry_valid), 32'd1);
    applyStimulus(0, 4'd0, 1, 0, 0, 0);
    checkOutput("conf_end",   32'(entry_valid), 32'd0);
    checkOutput("conf_count", 32'(count), 32'd0);
    checkOutput("conf_value", 32'(value), 32'h0123);
    idleCycle();

    keyPress(4'd9); keyPress(4'd8); keyPress(4'd7); keyPress(4'd6);
    checkOutput("full_enablen", 32'(enablen), 32'd1);
    keyPress(4'd5);
    checkOutput("full_value", 32'(value), 32'h9876);
    applyStimulus(0, 4'd0, 0, 1, 0, 0);
    checkOutput("cancel_value",   32'(value),   32'd0);
    checkOutput("cancel_count",   32'(count),   32'd0);
    checkOutput("cancel_enablen", 32'(enablen), 32'd0);
    idleCycle();

    keyPress(4'd4);
    for (int i = 0; i < TO; i++) begin
      applyStimulus(0, 4'd0, 0, 0, 1, 0);
      checkOutput("to_pulse", 32'(timeout), (i == TO - 1) ? 32'd1 : 32'd0);
      applyStimulus(0, 4'd0, 0, 0, 0, 0);
    end
    checkOutput("to_value", 32'(value), 32'd0);
    applyStimulus(0, 4'd0, 1, 0, 0, 0);
    checkOutput("idle_confirm", 32'(entry_valid), 32'd0);
    idleCycle();

    keyPress(4'd1); keyPress(4'd2);
    applyStimulus(0, 4'd0, 1, 1, 0, 0);
    checkOutput("cc_valid", 32'(entry_valid), 32'd0);
    checkOutput("cc_count", 32'(count), 32'd0);
    idleCycle();
    idleCycle();

    keyPress(4'd3);
    for (int i = 0; i < TO - 1; i++) begin
      applyStimulus(0, 4'd0, 0, 0, 1, 0);
      applyStimulus(0, 4'd0, 0, 0, 0, 0);
    end
    applyStimulus(1, 4'd7, 0, 0, 1, 0);
    checkOutput("keytick_timeout", 32'(timeout), 32'd0);
    checkOutput("keytick_count",   32'(count),   32'd2);
    applyStimulus(0, 4'd7, 0, 0, 0, 0);
    keyPress(4'hC);
    checkOutput("badkey_count", 32'(count), 32'd2);
    checkOutput("badkey_value", 32'(value), 32'h0037);

    // Asynchronous reset in the middle of an entry.
    #1 resetn = 0;
    #1 modelReset();
    compareAll();
    checkOutput("midrst_value", 32'(value), 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1 compareAll();
    end
    resetn = 1;
    idleCycle();
    idleCycle();

`ifdef ENTRY_BACKSPACE_EN
    keyPress(4'd1); keyPress(4'd2); keyPress(4'd3);
    applyStimulus(0, 4'd0, 0, 0, 0, 1);
    applyStimulus(0, 4'd0, 0, 0, 0, 0);
    checkOutput("bs_value", 32'(value), 32'h0012);
    checkOutput("bs_count", 32'(count), 32'd2);
    repeat (2) begin
      applyStimulus(0, 4'd0, 0, 0, 0, 1);
      applyStimulus(0, 4'd0, 0, 0, 0, 0);
    end
    checkOutput("bs_idle_count", 32'(count), 32'd0);
    checkOutput("bs_idle_busy",  32'(busy),  32'd0);
`endif

    // Random segments alternating busy keying and sparse keying so timeouts also occur.
    for (int seg = 0; seg < 8; seg++) begin
      int loadPct;
      loadPct = (seg % 2 == 0) ? 35 : 4;
      for (int c = 0; c < 400; c++) begin
        applyStimulus($urandom_range(0, 99) < loadPct,
                      4'($urandom_range(0, 11)),
                      $urandom_range(0, 99) < 3,
                      $urandom_range(0, 99) < 2,
                      $urandom_range(0, 99) < 30,
                      $urandom_range(0, 99) < 4);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
